// File: rtl/da_fir_seq_ctrl.sv
// da_fir_seq_ctrl: bit-serial 4-tap distributed-arithmetic FIR sequencer with shadowed coefficients
//   clk/rst            clock, asynchronous active-low reset
//   in_valid/in_ready  sample handshake, in_data signed DW-bit sample
//   coef_wr/sel/data   shadow coefficient write, committed at sample accept
//   out_valid/ready    result handshake, out_data signed OW-bit full-precision sum
//   busy               evaluating or holding a result
module da_fir_seq_ctrl #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = DW + CW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          coef_wr,
  input  logic [1:0]    coef_sel,
  input  logic [CW-1:0] coef_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          busy
);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t                r_state, w_state_nx;
  logic [DW-1:0]         r_x [4];
  logic signed [CW-1:0]  r_hs [4];
  logic signed [CW-1:0]  r_ha [4];
  logic signed [OW-1:0]  r_acc, r_out, w_l, w_acc_nx;
  logic [BW-1:0]         r_b;
  logic signed [CW+1:0]  w_lut [16];
  logic [3:0]            w_addr;
  logic                  w_accept, w_msb, w_last;
  always_comb begin
    for (int a = 0; a < 16; a++) begin
      w_lut[a] = '0;
      for (int i = 0; i < 4; i++) w_lut[a] = w_lut[a] + (a[i] ? (CW+2)'(r_ha[i]) : '0);
    end
  end
  assign w_addr    = {r_x[3][r_b], r_x[2][r_b], r_x[1][r_b], r_x[0][r_b]};
  assign w_l       = OW'(w_lut[w_addr]);
  assign w_msb     = r_b == BW'(DW - 1);
  assign w_last    = r_b == '0;
  // the sign plane carries negative weight in two's complement, so it is subtracted
  assign w_acc_nx  = (r_acc <<< 1) + (w_msb ? -w_l : w_l);
  assign in_ready  = rst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign out_data  = r_out;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = w_accept ? ACC :
                 (r_state == ACC && w_last) ? DONE :
                 (r_state == DONE && out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_x[i]  <= '0;
        r_hs[i] <= '0;
        r_ha[i] <= '0;
      end
      r_acc <= '0;
      r_out <= '0;
      r_b   <= '0;
    end else begin
      if (coef_wr) r_hs[coef_sel] <= coef_data;
      if (w_accept) begin
        r_x[0] <= in_data;
        for (int i = 1; i < 4; i++) r_x[i] <= r_x[i-1];
        r_ha  <= r_hs;
        r_acc <= '0;
        r_b   <= BW'(DW - 1);
      end else if (r_state == ACC) begin
        r_acc <= w_acc_nx;
        r_b   <= r_b - 1'b1;
        if (w_last) r_out <= w_acc_nx;
      end
    end
  end
endmodule

// File: tb/tb_da_fir_seq_ctrl.sv
// tb_da_fir_seq_ctrl: directed and randomized checks of da_fir_seq_ctrl against an arithmetic FIR model
module tb_da_fir_seq_ctrl;
  localparam int DW = 8;
  localparam int OW = 18;
  logic clk = 0, rst = 1, in_valid = 0, coef_wr = 0, out_ready = 0;
  logic [7:0] in_data = 0, coef_data = 0;
  logic [1:0] coef_sel = 0;
  logic in_ready, out_valid, busy;
  logic [OW-1:0] out_data;
  int sh[4], ah[4], x[4];
  int exp_q[$];
  int last_exp, cyc = 0, acc_cyc = 0, prev = 0, total = 0, bad = 0;
  da_fir_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_wr(coef_wr), .coef_sel(coef_sel), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  function automatic int fir();
    int s = 0;
    for (int i = 0; i < 4; i++) s += ah[i] * x[i];
    return s;
  endfunction
  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input bit acc);
    @(posedge clk);
    #1;
    if (acc) begin
      ah = sh;
      x[3] = x[2]; x[2] = x[1]; x[1] = x[0];
      x[0] = int'($signed(in_data));
      exp_q.push_back(fir());
      acc_cyc = cyc;
    end
    if (coef_wr) sh[coef_sel] = int'($signed(coef_data));
  endtask
  task automatic wr(input int sel, input int val);
    coef_wr = 1;
    coef_sel = 2'(sel);
    coef_data = val[7:0];
    step(0);
    coef_wr = 0;
  endtask
  task automatic do_accept(input int v);
    int n = 0;
    in_valid = 1;
    in_data = v[7:0];
    while (!in_ready && n < 50) begin
      step(0);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    step(1);
    in_valid = 0;
    coef_wr = 0;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      step(0);
      n++;
    end
    chk({tag, "_latency"}, cyc - acc_cyc, DW);
    last_exp = exp_q.pop_front();
    chk({tag, "_data"}, $signed(out_data), last_exp);
  endtask
  task automatic take(input string tag);
    out_ready = 1;
    step(0);
    out_ready = 0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask
  task automatic do_rst(input string tag);
    rst = 0;
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_data"}, out_data, 0);
    step(0);
    step(0);
    chk({tag, "_held_valid"}, out_valid, 0);
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      sh[i] = 0; ah[i] = 0; x[i] = 0;
    end
    exp_q.delete();
    #1;
    chk({tag, "_release_ready"}, in_ready, 1);
  endtask
  initial begin
    int imp[4] = '{1, 0, 0, 0};
    #1 do_rst("reset");
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    for (int j = 0; j < 4; j++) begin
      do_accept(imp[j]);
      wait_valid("impulse");
      chk("impulse_const", last_exp, j + 1);
      take("impulse");
    end
    do_rst("reset2");
    wr(0, 127);
    do_accept(-128);
    wait_valid("ext_neg");
    chk("ext_neg_const", last_exp, -16256);
    take("ext_neg");
    for (int i = 0; i < 4; i++) wr(i, -128);
    for (int j = 0; j < 4; j++) begin
      do_accept(-128);
      wait_valid("ext_fill");
      take("ext_fill");
    end
    chk("ext_max_const", last_exp, 65536);
    do_rst("reset3");
    wr(0, 1); wr(1, 3);
    do_accept(2);
    step(0);
    wr(0, 5);
    wait_valid("commit1");
    chk("commit1_const", last_exp, 2);
    take("commit1");
    coef_wr = 1; coef_sel = 1; coef_data = 8'd9;
    do_accept(1);
    wait_valid("commit2");
    chk("commit2_const", last_exp, 11);
    take("commit2");
    do_accept(0);
    wait_valid("commit3");
    take("commit3");
    do_accept(int'($urandom_range(255)) - 128);
    wait_valid("bp");
    in_valid = 1;
    in_data = 8'($urandom);
    for (int k = 0; k < 5; k++) begin
      step(0);
      chk("bp_hold_data", $signed(out_data), last_exp);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step(1);
    out_ready = 0;
    in_valid = 0;
    chk("bp_same_edge_valid", out_valid, 0);
    chk("bp_same_edge_busy", busy, 1);
    wait_valid("bp2");
    take("bp2");
    out_ready = 1;
    for (int j = 0; j < 4; j++) begin
      int n = 0;
      coef_wr = 1'($urandom);
      coef_sel = 2'($urandom);
      coef_data = 8'($urandom);
      in_valid = 1;
      in_data = 8'($urandom);
      if (j > 0) begin
        while (!in_ready && n < 40) begin
          step(0);
          n++;
        end
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", $signed(out_data), exp_q.pop_front());
      end
      prev = acc_cyc;
      step(1);
      coef_wr = 0;
      chk("b2b_busy", busy, 1);
      if (j > 0) chk("b2b_spacing", acc_cyc - prev, DW + 1);
    end
    in_valid = 0;
    out_ready = 0;
    wait_valid("b2b_last");
    take("b2b_last");
    for (int j = 0; j < 6; j++) begin
      wr(int'($urandom_range(3)), int'($urandom_range(255)));
      do_accept(int'($urandom_range(255)) - 128);
      step(0);
      wr(int'($urandom_range(3)), int'($urandom_range(255)));
      wait_valid("rand");
      take("rand");
    end
    do_accept(int'($urandom_range(127)) + 1);
    repeat (4) step(0);
    do_rst("reset_mid");
    for (int k = 0; k < 10; k++) begin
      step(0);
      chk("post_rst_quiet", out_valid, 0);
    end
    do_accept(1);
    wait_valid("post_rst_impulse");
    chk("post_rst_zero", last_exp, 0);
    take("post_rst_impulse");
    for (int i = 0; i < 4; i++) wr(i, 1);
    do_accept(0);
    wait_valid("post_rst_taps");
    chk("post_rst_taps_const", last_exp, 1);
    take("post_rst_taps");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
